// File: rtl/prbs5_checker.sv
// PRBS5 (x^5+x^3+1) receive checker: self-synchronises to the serial stream,
// then runs a flywheel generator and reports lock, error strobes and a saturating count.
module prbs5_checker #(
  parameter int LOCK_THRESH = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bit_valid,
  input  logic               bit_in,
  input  logic               clr_count,
  output logic               locked,
  output logic               err_pulse,
  output logic [COUNT_W-1:0] err_count
);

  typedef enum logic [1:0] {S_FILL, S_VERIFY, S_LOCKED} state_t;

  localparam logic [7:0] LOCK_T   = LOCK_THRESH[7:0];
  localparam logic [7:0] UNLOCK_T = UNLOCK_ERRS[7:0];

  state_t       state, state_nxt;
  logic [4:0]   hist;
  logic [2:0]   fill_cnt;
  logic [7:0]   match_cnt;
  logic [7:0]   miss_cnt;
  logic         expected;
  logic         mismatch;
  logic         hit;

  // hist[0] is the oldest bit; the next sequence bit is b[n] ^ b[n+2].
  assign expected = hist[0] ^ hist[2];
  assign mismatch = bit_in ^ expected;
  // An all-zero history is not a legal LFSR state, so it never counts towards lock.
  assign hit      = ~mismatch & (hist != '0);

  // NOTE: every register is cleared by the async reset, so the first post-reset edge
  // always starts a fresh acquisition from FILL with no stale history or counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bit_valid) begin
      unique case (state)
        S_FILL:   if (fill_cnt == 3'd4) state_nxt = S_VERIFY;
        S_VERIFY: if (hit && (match_cnt + 8'd1 == LOCK_T)) state_nxt = S_LOCKED;
        S_LOCKED: if (mismatch && (miss_cnt + 8'd1 == UNLOCK_T)) state_nxt = S_FILL;
        default:  state_nxt = S_FILL;
      endcase
    end
  end

  always_comb begin
    locked = (state == S_LOCKED);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of hist/counters, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist      <= '0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (bit_valid) begin
        unique case (state)
          S_FILL: begin
            hist      <= {bit_in, hist[4:1]};
            fill_cnt  <= fill_cnt + 3'd1;
            match_cnt <= '0;
          end
          S_VERIFY: begin
            hist      <= {bit_in, hist[4:1]};
            match_cnt <= hit ? match_cnt + 8'd1 : 8'd0;
            fill_cnt  <= '0;
            miss_cnt  <= '0;
          end
          S_LOCKED: begin
            // Flywheel: the local generator advances on its own prediction.
            hist <= {expected, hist[4:1]};
            if (mismatch) begin
              err_pulse <= 1'b1;
              miss_cnt  <= miss_cnt + 8'd1;
              if (err_count != '1) err_count <= err_count + COUNT_W'(1);
            end else begin
              miss_cnt <= '0;
            end
          end
          default: hist <= hist;
        endcase
      end
      if (clr_count) err_count <= '0;
    end
  end

endmodule

// File: tb/tb_prbs5_checker.sv
// Self-checking bench for prbs5_checker: queue-based reference model, per-cycle compare,
// directed scenarios plus randomized error injection; a COUNT_W=3 instance covers saturation.
module tb_prbs5_checker;

  localparam int LOCK_THRESH = 8;
  localparam int UNLOCK_ERRS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        bit_valid;
  logic        bit_in;
  logic        clr_count;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked_s, pulse_s;
  logic [2:0]  count_s;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  prbs5_checker #(.LOCK_THRESH(LOCK_THRESH), .UNLOCK_ERRS(UNLOCK_ERRS), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in), .clr_count(clr_count),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  prbs5_checker #(.LOCK_THRESH(LOCK_THRESH), .UNLOCK_ERRS(UNLOCK_ERRS), .COUNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .bit_valid(bit_valid), .bit_in(bit_in), .clr_count(clr_count),
    .locked(locked_s), .err_pulse(pulse_s), .err_count(count_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: phase 0 acquire 5 bits, 1 verify run, 2 locked (flywheel).
  int  m_phase, m_fill, m_run, m_miss, m_cnt, m_cnt_s;
  bit  m_pulse;
  bit  m_hist[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_fill = 0; m_run = 0; m_miss = 0;
      m_cnt = 0; m_cnt_s = 0; m_pulse = 0;
      m_hist.delete();
    end else begin
      bit pred, nz;
      m_pulse = 0;
      if (bit_valid) begin
        pred = (m_hist.size() >= 5) ? (m_hist[m_hist.size()-5] ^ m_hist[m_hist.size()-3]) : 1'b0;
        nz = 0;
        foreach (m_hist[i]) nz |= m_hist[i];
        case (m_phase)
          0: begin
            m_hist.push_back(bit_in);
            m_fill++;
            if (m_fill == 5) begin m_phase = 1; m_run = 0; end
          end
          1: begin
            m_hist.push_back(bit_in);
            if (bit_in == pred && nz) m_run++;
            else m_run = 0;
            if (m_run == LOCK_THRESH) begin m_phase = 2; m_miss = 0; end
          end
          default: begin
            m_hist.push_back(pred);
            if (bit_in != pred) begin
              m_pulse = 1;
              m_cnt   = (m_cnt   < 65535) ? m_cnt + 1   : m_cnt;
              m_cnt_s = (m_cnt_s < 7)     ? m_cnt_s + 1 : m_cnt_s;
              m_miss++;
              if (m_miss == UNLOCK_ERRS) begin m_phase = 0; m_fill = 0; end
            end else begin
              m_miss = 0;
            end
          end
        endcase
        while (m_hist.size() > 5) void'(m_hist.pop_front());
      end
      if (clr_count) begin m_cnt = 0; m_cnt_s = 0; end
    end
  end

  always @(negedge clk) begin
    check("locked",        locked,    32'(m_phase == 2));
    check("err_pulse",     err_pulse, 32'(m_pulse));
    check("err_count",     err_count, m_cnt);
    check("locked_w3",     locked_s,  32'(m_phase == 2));
    check("err_pulse_w3",  pulse_s,   32'(m_pulse));
    check("err_count_w3",  count_s,   m_cnt_s);
  end

  int pulse_cycles = 0;
  always @(negedge clk) if (err_pulse) pulse_cycles++;

  // Stimulus generator: Fibonacci LFSR whose bit 0 obeys b[n+5] = b[n] ^ b[n+2].
  logic [4:0] gen;
  int valid_cnt, lock_idx;

  task automatic gen_step(output bit b);
    b   = gen[0];
    gen = {gen[0] ^ gen[2], gen[4:1]};
  endtask

  // Called just after a negedge; returns just after a negedge.
  task automatic send_bit(input bit b, input int gap, input bit clr);
    bit_valid = 1'b1; bit_in = b; clr_count = clr;
    valid_cnt++;
    @(negedge clk);
    if (locked && lock_idx < 0) lock_idx = valid_cnt;
    bit_valid = 1'b0; clr_count = 1'b0;
    for (int i = 1; i < gap; i++) begin
      bit_in = ~bit_in;
      @(negedge clk);
    end
  endtask

  task automatic clean(input int n, input int gap);
    bit b;
    for (int i = 0; i < n; i++) begin
      gen_step(b);
      send_bit(b, gap, 1'b0);
    end
  endtask

  task automatic err_bit(input int gap, input bit clr);
    bit b;
    gen_step(b);
    send_bit(~b, gap, clr);
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0; clr_count = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    bit_valid = 1'b0; clr_count = 1'b0; bit_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    valid_cnt = 0; lock_idx = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pc;
    reset = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; clr_count = 1'b0;
    gen = 5'b11111;
    #12;
    check("reset_locked", locked,    0);
    check("reset_pulse",  err_pulse, 0);
    check("reset_count",  err_count, 0);
    @(negedge clk);
    reset = 1'b1;

    // Clean lock: lock on valid bit 5 + LOCK_THRESH = 13.
    valid_cnt = 0; lock_idx = -1;
    clean(200, 4);
    check("clean_lock_idx", lock_idx, 13);
    check("clean_count", err_count, 0);
    check("clean_pulses", pulse_cycles, 0);

    // Single error: one-cycle pulse, flywheel unaffected.
    err_bit(4, 1'b0);
    idle(2);
    check("single_pulses", pulse_cycles, 1);
    check("single_count", err_count, 1);
    check("single_locked", locked, 1);
    clean(50, 4);
    idle(2);
    check("after_single_pulses", pulse_cycles, 1);
    check("after_single_count", err_count, 1);

    // Loss of lock after 4 consecutive errors, then relock in 13 bits.
    clr_count = 1'b1; @(negedge clk); clr_count = 1'b0;
    check("clr_idle", err_count, 0);
    for (int i = 0; i < 4; i++) begin
      err_bit(4, 1'b0);
      if (i == 2) check("still_locked_3", locked, 1);
    end
    check("loss_locked", locked, 0);
    check("loss_count", err_count, 4);
    valid_cnt = 0; lock_idx = -1;
    clean(40, 4);
    check("relock_idx", lock_idx, 13);
    check("relock_count", err_count, 4);

    // Gapped strobes with toggling bit_in between them.
    do_reset();
    gen = 5'b11111;
    clean(20, 50);
    check("gapped_lock_idx", lock_idx, 13);

    // All-zero stream never locks.
    do_reset();
    for (int i = 0; i < 300; i++) send_bit(1'b0, 1, 1'b0);
    idle(1);
    check("zero_never_locked", lock_idx, -1);
    check("zero_count", err_count, 0);

    // Randomized errors, gaps and clears, checked cycle-by-cycle against the model.
    do_reset();
    gen = 5'($urandom_range(1, 31));
    clean(20, $urandom_range(1, 3));
    for (int i = 0; i < 400; i++) begin
      bit b;
      gen_step(b);
      send_bit(($urandom_range(0, 7) == 0) ? ~b : b, $urandom_range(1, 3),
               $urandom_range(0, 15) == 0);
    end
    idle(2);

    // Saturation of the 3-bit counter, then clear coincident with an error.
    do_reset();
    gen = 5'b11111;
    clean(15, 2);
    check("sat_locked", locked, 1);
    for (int i = 0; i < 10; i++) begin
      err_bit(2, 1'b0);
      clean(3, 2);
    end
    idle(2);
    check("sat_count_w3", count_s, 7);
    check("sat_count_w16", err_count, 10);
    pc = pulse_cycles;
    err_bit(4, 1'b1);
    idle(1);
    check("clr_wins_count", err_count, 0);
    check("clr_wins_count_w3", count_s, 0);
    check("clr_wins_pulse", pulse_cycles, pc + 1);
    err_bit(4, 1'b0);
    check("pre_reset_count", err_count, 1);

    // Asynchronous reset mid-lock.
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_locked", locked, 0);
    check("async_locked_w3", locked_s, 0);
    check("async_count", err_count, 0);
    @(negedge clk);
    reset = 1'b1;
    valid_cnt = 0; lock_idx = -1;
    gen = 5'b11111;
    clean(20, 4);
    check("post_reset_lock_idx", lock_idx, 13);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs5_checker.md
Name: prbs5_checker

Overview:
- Receive-side counterpart of the 5-bit LFSR pattern generator.
- Samples the serial bit stream taken from generator bit 0 (one bit per generator step), self-synchronises to the x^5+x^3+1 sequence (period 31), and keeps a local flywheel generator running once locked.
- Reports lock status, per-bit error strobes and a saturating error count to the lab top level.

Parameters:
- LOCK_THRESH, 8, consecutive correct predictions needed to declare lock (1..255).
- UNLOCK_ERRS, 4, consecutive mispredictions while locked that force loss of lock (1..255).
- COUNT_W, 16, width of err_count.

Ports:
- clk  input  1  system clock (50 MHz board clock); all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- bit_valid  input  1  one-cycle strobe; bit_in is consumed only in cycles where bit_valid=1 (generator runs on a divided clock).
- bit_in  input  1  received serial bit (generator lfsr[0]).
- clr_count  input  1  synchronous clear of err_count.
- locked  output  1  1 while in LOCKED state.
- err_pulse  output  1  one-cycle strobe: mismatch detected while locked.
- err_count  output  COUNT_W  saturating mismatch count, accumulated while locked.

Behaviour:
- Sequence model: transmitted bits obey b[n+5] = b[n] XOR b[n+2].
- hist[4:0] holds the last 5 accepted bits; hist[0] is the oldest. Shift on accept: hist <= {new, hist[4:1]}. expected = hist[0] ^ hist[2].
- Reset (reset=0, async): state=FILL, hist=0, fill_cnt=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0.
- Cycles with bit_valid=0: no state change, except that err_pulse returns to 0 and clr_count still applies.
- FILL: each valid bit shifts bit_in into hist and increments fill_cnt. After the 5th valid bit, go to VERIFY with match_cnt=0.
- VERIFY, each valid bit:
  - Shift bit_in into hist.
  - If bit_in==expected and hist!=0: match_cnt++.
  - Otherwise: match_cnt=0. This includes the all-zero history, which is an illegal LFSR state and can never produce lock.
  - When match_cnt reaches LOCK_THRESH: go to LOCKED and set locked=1 on that same edge. Lock latency = 5 + LOCK_THRESH valid bits after reset on a clean stream.
- LOCKED, each valid bit:
  - Flywheel: hist shifts in expected, not bit_in.
  - On mismatch: err_pulse=1 for exactly one clk cycle, err_count++ (holds at all-ones, no wrap), miss_cnt++.
  - On match: miss_cnt=0.
  - When miss_cnt reaches UNLOCK_ERRS: go to FILL with fill_cnt=0 and locked=0 on that edge. The bit that triggers unlock is still counted in err_count.
- No errors are counted in FILL or VERIFY.
- clr_count=1: err_count becomes 0 on that edge. If an error occurs in the same cycle, clear wins (result 0).
- err_pulse is registered and never asserts outside LOCKED.
- Reset asserted mid-operation returns to the reset values asynchronously. After release, reacquisition starts from FILL.

Test Plan:
- Clean lock, default params: reset, then generator seeded 5'b11111, one valid bit every 4 clks for 200 bits → locked rises on the edge of valid bit 13; err_count stays 0; err_pulse never asserts.
- Single error: after lock, invert one bit → err_pulse high for 1 clk, err_count=1, locked stays 1; the following 50 clean bits give no further pulses (flywheel is not corrupted).
- Loss of lock: after lock, invert 4 consecutive valid bits → err_count=4, locked falls on the 4th; on resuming the clean stream, locked rises again after exactly 13 valid bits; err_count stays 4.
- All-zero stream: bit_in=0 on 300 valid strobes → locked never asserts, err_count=0.
- Gapped strobes: bit_valid once every 50 clks with bit_in toggling between strobes → identical lock timing to the clean-lock case counted in valid bits; non-strobe values are ignored.
- Saturation and clear: COUNT_W=3 with a continuous stream of single-bit errors separated by correct bits → err_count stops at 7. clr_count coincident with an error pulse → err_count=0. reset=0 mid-lock → locked=0 immediately, without waiting for a clk edge.
